matvec_engine: RTL and testbench
================================

// Module: matvec_engine
// PURPOSE
//  Fixed-point matrix-vector engine, y = W*x + b, directly downstream of the parameter tensors.
//  Drives select lines into the weight tensor_2d (W), input tensor_1d (x) and bias tensor_1d (b).
//  Consumes their combinational param_out and writes each result row into an output tensor_1d (y).
//  One MAC per cycle; this is the compute core of an RNN gate evaluation.
// PARAMETERS
//  ROW_BITS   2  log2 rows of W; also the width of the b and y selects
//  COL_BITS   4  log2 cols of W; also the width of the x select
//  FRAC_BITS  8  fractional bits of the signed 16-bit Q format (default Q8.8)
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         synchronous active-low reset (sampled on posedge clk)
//  start      in   1         begin a run; honoured only in IDLE
//  busy       out  1         high in every state except IDLE
//  done       out  1         one-cycle pulse when the run completes
//  ovf        out  1         sticky saturation flag for the current run; cleared on accepted start
//  w_sel_r    out  ROW_BITS  W row select
//  w_sel_c    out  COL_BITS  W column select
//  w_data     in   16        W[w_sel_r][w_sel_c], combinational, same cycle
//  x_sel      out  COL_BITS  x select, always equal to w_sel_c
//  x_data     in   16        x[x_sel], same cycle
//  b_sel      out  ROW_BITS  b select, always equal to w_sel_r
//  b_data     in   16        b[b_sel], same cycle
//  y_write    out  1         write strobe to the y tensor
//  y_sel      out  ROW_BITS  y select, equal to w_sel_r
//  y_data     out  16        saturated result row
// BEHAVIOUR
//  - Reset: state IDLE; row, col and acc counters 0; busy/done/ovf/y_write 0; y_data 0; all selects 0.
//  - FSM states: IDLE, ACC, WB, DONE.
//    IDLE --start--> ACC (row=0, col=0, acc=0, ovf=0).
//    ACC: acc += sext(w_data*x_data), a 32-bit signed product; col++.
//         On col == 2^COL_BITS-1, go to WB after that cycle's accumulate.
//    WB: y_write=1, y_sel=row, y_data=sat16((acc + (sext(b_data) <<< FRAC_BITS)) >>> FRAC_BITS).
//        If row is last, go to DONE; else row++, col=0, acc=0, go to ACC.
//    DONE: done=1 for exactly one cycle, then IDLE.
//  - Accumulator width: 32+COL_BITS+1 signed bits. No intermediate overflow is possible.
//  - Shift is arithmetic (floor toward -inf); there is no rounding.
//  - sat16 clamps to [0x8000, 0x7FFF]. Any clamp sets ovf, which holds until the next accepted start.
//  - y_write, y_sel and y_data are combinational decodes of state/registers and are valid only in WB.
//    y_data is 0 outside WB.
//  - Timing: start accepted at edge 0. Rows are R=2^ROW_BITS, columns C=2^COL_BITS.
//    First y_write occurs in cycle C+1; done is high in cycle R*(C+1)+1.
//    Defaults give 69 cycles to done.
//  - start while busy is ignored with no effect; start held high re-launches from DONE->IDLE->ACC.
//  - rst_n low mid-run: at the next edge go to IDLE and drop busy.
//    No y_write or done is issued afterwards, and partial y contents are left as written.
//  - Tensor contents must be stable while busy; the engine does not snapshot them.
// STRUCTURE
//  - Shared package rnn_pkg: FSM state enum; Q-format constants (DATA_W=16, FRAC_BITS default);
//    sat16 function; MIN/MAX constants 16'sh8000 and 16'sh7FFF.
//  - One sub-module, fxp_mac: registered signed multiply-accumulate with clear/enable.
//  - Top level holds the FSM, row/col counters, the bias/shift/saturate path and ovf.
// TESTING (all values Q8.8, default params)
//  1. W=identity (0x0100 diag), x[j]=j<<8, b=0 -> y[i]=i<<8, 4 y_writes, done in cycle 69, ovf=0.
//  2. W=0, b[i]=0x0280 for all i -> y[i]=0x0280 for every row.
//  3. W=0xFF00 (-1.0) everywhere, x=0x0100 everywhere, b=0 -> y[i]=0xF000 (-16.0).
//  4. W=x=0x7FFF everywhere -> y=0x7FFF, ovf=1. Then W=0x8000, x=0x7FFF -> y=0x8000, ovf=1.
//     Next start with benign data -> ovf cleared.
//  5. Floor: W[0][0]=0x0001, x[0]=0x0080, rest 0 -> y[0]=0x0000. With W[0][0]=0xFFFF -> y[0]=0xFFFF.
//  6. start pulsed at cycles 5 and 30 of a run -> ignored, single done at cycle 69.
//     rst_n low at cycle 20 -> busy=0 next edge, no further y_write; fresh start then completes as test 1.

Source files
------------

// File: rtl/rnn_pkg.sv
// Shared Q-format constants, FSM state encoding and saturation helpers for
// the RNN compute blocks.
package rnn_pkg;

  localparam int DATA_W        = 16;
  localparam int FRAC_BITS_DEF = 8;

  localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;
  localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Callers sign-extend their wide result into 64 bits before clamping.
  function automatic logic sat_hit(input logic signed [63:0] v);
    return (v > 64'sd32767) || (v < -64'sd32768);
  endfunction

  function automatic logic [DATA_W-1:0] sat16(input logic signed [63:0] v);
    logic [DATA_W-1:0] r;
    if (v > 64'sd32767) begin
      r = Q_MAX;
    end else if (v < -64'sd32768) begin
      r = Q_MIN;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/matvec_engine_fxp_mac.sv
// Registered signed 16x16 multiply-accumulate with synchronous clear and
// enable. The accumulator is wide enough that a full row cannot overflow.
module fxp_mac #(
  parameter int ACC_W = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  output logic [ACC_W-1:0] acc
);

  logic signed [31:0]      prod;
  logic        [ACC_W-1:0] prod_ext;
  logic        [ACC_W-1:0] acc_d;
  logic        [ACC_W-1:0] acc_q;

  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

  // Clear wins over enable so a new row can never inherit a stale sum.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// Fixed-point y = W*x + b engine: walks W row by row, one MAC per cycle,
// then adds the bias, shifts back to Q format, saturates and writes y.
module matvec_engine
  import rnn_pkg::*;
#(
  parameter int ROW_BITS  = 2,
  parameter int COL_BITS  = 4,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [ROW_BITS-1:0] w_sel_r,
  output logic [COL_BITS-1:0] w_sel_c,
  input  logic [15:0]         w_data,
  output logic [COL_BITS-1:0] x_sel,
  input  logic [15:0]         x_data,
  output logic [ROW_BITS-1:0] b_sel,
  input  logic [15:0]         b_data,
  output logic                y_write,
  output logic [ROW_BITS-1:0] y_sel,
  output logic [15:0]         y_data,
  output logic [1:0]          dbg_state
);

  localparam int ACC_W = 32 + COL_BITS + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [ROW_BITS-1:0] ROW_LAST = {ROW_BITS{1'b1}};
  localparam logic [COL_BITS-1:0] COL_LAST = {COL_BITS{1'b1}};

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                ovf_q, ovf_d;

  logic                mac_clr;
  logic                mac_en;
  logic [ACC_W-1:0]    acc;

  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] bias_ext;
  logic signed [SUM_W-1:0] bias_sh;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;
  logic signed [63:0]      shifted_64;
  logic                    clamp;

  fxp_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (mac_clr),
    .en    (mac_en),
    .a     (w_data),
    .b     (x_data),
    .acc   (acc)
  );

  // Bias is aligned to the product's 2*FRAC_BITS scale before the add;
  // the arithmetic right shift floors toward -inf with no rounding.
  always_comb begin
    acc_ext    = {acc[ACC_W-1], acc};
    bias_ext   = {{(SUM_W-16){b_data[15]}}, b_data};
    bias_sh    = bias_ext <<< FRAC_BITS;
    sum        = acc_ext + bias_sh;
    shifted    = sum >>> FRAC_BITS;
    shifted_64 = {{(64-SUM_W){shifted[SUM_W-1]}}, shifted};
    clamp      = sat_hit(shifted_64);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ovf_d   = ovf_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    done    = 1'b0;
    y_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACC;
          row_d   = '0;
          col_d   = '0;
          ovf_d   = 1'b0;
          mac_clr = 1'b1;
        end
      end
      ST_ACC: begin
        mac_en = 1'b1;
        col_d  = col_q + 1'b1;
        if (col_q == COL_LAST) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        y_write = 1'b1;
        mac_clr = 1'b1;
        if (clamp) begin
          ovf_d = 1'b1;
        end
        if (row_q == ROW_LAST) begin
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          col_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign ovf       = ovf_q;
  assign w_sel_r   = row_q;
  assign w_sel_c   = col_q;
  assign x_sel     = col_q;
  assign b_sel     = row_q;
  assign y_sel     = row_q;
  assign y_data    = y_write ? sat16(shifted_64) : 16'h0000;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine: tensors modelled as arrays, expected
// y rows pushed to a queue and checked by an independent monitor.
module tb_matvec_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [1:0]  w_sel_r;
  logic [3:0]  w_sel_c;
  logic [15:0] w_data;
  logic [3:0]  x_sel;
  logic [15:0] x_data;
  logic [1:0]  b_sel;
  logic [15:0] b_data;
  logic        y_write;
  logic [1:0]  y_sel;
  logic [15:0] y_data;
  logic [1:0]  dbg_state;

  logic [15:0] w_mem [4][16];
  logic [15:0] x_mem [16];
  logic [15:0] b_mem [4];

  logic [17:0] exp_q [$];
  int n_cmp;
  int n_fail;

  matvec_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .w_sel_r   (w_sel_r),
    .w_sel_c   (w_sel_c),
    .w_data    (w_data),
    .x_sel     (x_sel),
    .x_data    (x_data),
    .b_sel     (b_sel),
    .b_data    (b_data),
    .y_write   (y_write),
    .y_sel     (y_sel),
    .y_data    (y_data),
    .dbg_state (dbg_state)
  );

  assign w_data = w_mem[w_sel_r][w_sel_c];
  assign x_data = x_mem[x_sel];
  assign b_data = b_mem[b_sel];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && y_write) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL y_unexpected: got row %0d data %h, required no write", y_sel, y_data);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({y_sel, y_data} !== e) begin
          n_fail++;
          $display("FAIL y_row: got row %0d data %h, required row %0d data %h",
                   y_sel, y_data, e[17:16], e[15:0]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic fill(input logic [15:0] w, input logic [15:0] x, input logic [15:0] b);
    for (int i = 0; i < 4; i++) begin
      b_mem[i] = b;
      for (int j = 0; j < 16; j++) w_mem[i][j] = w;
    end
    for (int j = 0; j < 16; j++) x_mem[j] = x;
  endtask

  task automatic push4(input logic [15:0] y0, input logic [15:0] y1,
                       input logic [15:0] y2, input logic [15:0] y3);
    exp_q.push_back({2'd0, y0});
    exp_q.push_back({2'd1, y1});
    exp_q.push_back({2'd2, y2});
    exp_q.push_back({2'd3, y3});
  endtask

  // Launches a run at edge 0; cycle n is the interval after edge n-1.
  // Optional start pulses in given cycles, optional reset asserted in rst_at.
  task automatic run(input string name, input logic exp_ovf,
                     input int pulse_a, input int pulse_b, input int rst_at);
    int cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_a || cyc == pulse_b);
      if (cyc == 1) check({name, "_ovf_clr"}, {31'd0, ovf}, 32'd0);
      if (rst_at > 0 && cyc == rst_at) begin
        rst_n = 1'b0;
        seen  = 1'b1;
      end else if (done) begin
        seen = 1'b1;
        check({name, "_done_cycle"}, cyc, 32'd69);
        check({name, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
      end
    end
    start = 1'b0;
    if (!seen) check({name, "_timeout"}, cyc, 32'd69);
    if (rst_at > 0) begin
      @(negedge clk);
      check({name, "_busy_after_rst"}, {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (done || busy) begin
          check({name, "_quiet_after_rst"}, {30'd0, done, busy}, 32'd0);
          break;
        end
      end
    end else begin
      @(negedge clk);
      check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
    end
    check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    fill(16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'd0, busy},    32'd0);
    check("rst_done",   {31'd0, done},    32'd0);
    check("rst_ovf",    {31'd0, ovf},     32'd0);
    check("rst_ywrite", {31'd0, y_write}, 32'd0);
    check("rst_ydata",  {16'd0, y_data},  32'd0);
    check("rst_sels",   {22'd0, w_sel_r, w_sel_c, x_sel, b_sel, y_sel}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: identity W, x[j] = j.0
    fill(16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) w_mem[i][i] = 16'h0100;
    for (int j = 0; j < 16; j++) x_mem[j] = 16'(j << 8);
    push4(16'h0000, 16'h0100, 16'h0200, 16'h0300);
    run("identity", 1'b0, 0, 0, 0);

    // 2: bias only
    fill(16'h0000, 16'h0100, 16'h0280);
    push4(16'h0280, 16'h0280, 16'h0280, 16'h0280);
    run("bias", 1'b0, 0, 0, 0);

    // 3: -1.0 * 1.0 summed over 16 columns = -16.0
    fill(16'hFF00, 16'h0100, 16'h0000);
    push4(16'hF000, 16'hF000, 16'hF000, 16'hF000);
    run("neg", 1'b0, 0, 0, 0);

    // 4: positive then negative saturation, then benign run clears ovf
    fill(16'h7FFF, 16'h7FFF, 16'h0000);
    push4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run("sat_pos", 1'b1, 0, 0, 0);
    check("ovf_sticky_idle", {31'd0, ovf}, 32'd1);
    fill(16'h8000, 16'h7FFF, 16'h0000);
    push4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run("sat_neg", 1'b1, 0, 0, 0);
    fill(16'h0000, 16'h0100, 16'h0080);
    push4(16'h0080, 16'h0080, 16'h0080, 16'h0080);
    run("benign", 1'b0, 0, 0, 0);

    // 5: floor behaviour of the shift
    fill(16'h0000, 16'h0000, 16'h0000);
    w_mem[0][0] = 16'h0001;
    x_mem[0]    = 16'h0080;
    push4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run("floor_pos", 1'b0, 0, 0, 0);
    w_mem[0][0] = 16'hFFFF;
    push4(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    run("floor_neg", 1'b0, 0, 0, 0);

    // 6: start while busy ignored; reset mid-run after row 0; fresh run
    fill(16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) w_mem[i][i] = 16'h0100;
    for (int j = 0; j < 16; j++) x_mem[j] = 16'(j << 8);
    push4(16'h0000, 16'h0100, 16'h0200, 16'h0300);
    run("start_busy", 1'b0, 5, 30, 0);
    exp_q.push_back({2'd0, 16'h0000});
    run("mid_reset", 1'b0, 0, 0, 20);
    push4(16'h0000, 16'h0100, 16'h0200, 16'h0300);
    run("after_reset", 1'b0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
